// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - request/response and RAM-port bundle for ram_arbiter
interface ram_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              m0_re;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_re;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_lock;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  m0_re, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_re, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_addr, ram_wdata, ram_re, ram_we,
        input  ram_rdata
    );

    modport master (
        output m0_re, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_re, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_addr, ram_wdata, ram_re, ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-master single-port RAM arbiter with lock and read-return routing
// Optional RAM_ARB_ROUND_ROBIN_EN: round-robin conflict resolution instead of fixed priority.
module ram_arbiter #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic {OPEN, LOCKED} lock_state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_M0, TAG_M1} rd_tag_t;

    localparam logic [4:0] LOCK_LAST = 5'(MAX_WAIT + 3);

    lock_state_t state, state_nxt;
    rd_tag_t     rd_tag, rd_tag_nxt;
    logic [4:0]  lock_cnt, lock_cnt_nxt;
    logic        force_m0, force_m0_nxt;
    logic        req0, req1, gnt0, gnt1, rd0, rd1, conflict_m1;

    // Requests are masked during reset so every output is quiet while rst_n is low.
    assign req0 = rst_n & (bus.m0_re | bus.m0_we);
    assign req1 = rst_n & (bus.m1_re | bus.m1_we);

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic rr_m1;
    assign conflict_m1 = rr_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_m1 <= 1'b0;
        end else if (req0 && req1 && state == OPEN) begin
            rr_m1 <= gnt0;
        end
    end
`else
    localparam logic [3:0] MAX_WAIT_L = 4'(MAX_WAIT);
    logic [3:0] wait_cnt;
    assign conflict_m1 = (wait_cnt >= MAX_WAIT_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (req1 && !gnt1) begin
            wait_cnt <= (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        force_m0_nxt = force_m0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        case (state)
            OPEN: begin
                if (req0 && req1) begin
                    if (force_m0 || !conflict_m1) gnt0 = 1'b1;
                    else                          gnt1 = 1'b1;
                    force_m0_nxt = 1'b0;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
                if (gnt1 && bus.m1_lock) begin
                    state_nxt    = LOCKED;
                    lock_cnt_nxt = 5'd0;
                end
            end
            default: begin
                gnt1 = req1;
                if (!bus.m1_lock || !req1) begin
                    state_nxt = OPEN;
                end else if (lock_cnt == LOCK_LAST) begin
                    // Lock held too long: reopen and let master 0 win the next conflict.
                    state_nxt    = OPEN;
                    force_m0_nxt = 1'b1;
                end else begin
                    lock_cnt_nxt = lock_cnt + 5'd1;
                end
            end
        endcase
    end

    // A simultaneous re/we is served as a write, so it never produces read data.
    assign rd0        = gnt0 & bus.m0_re & ~bus.m0_we;
    assign rd1        = gnt1 & bus.m1_re & ~bus.m1_we;
    assign rd_tag_nxt = rd0 ? TAG_M0 : (rd1 ? TAG_M1 : TAG_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= OPEN;
            lock_cnt <= 5'd0;
            force_m0 <= 1'b0;
            rd_tag   <= TAG_NONE;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            force_m0 <= force_m0_nxt;
            rd_tag   <= rd_tag_nxt;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.ram_re    = rd0 | rd1;
    assign bus.ram_we    = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
    assign bus.ram_addr  = gnt0 ? bus.m0_addr  : (gnt1 ? bus.m1_addr  : {ADDR_W{1'b0}});
    assign bus.ram_wdata = gnt0 ? bus.m0_wdata : (gnt1 ? bus.m1_wdata : {DATA_W{1'b0}});

    assign bus.m0_rvalid = (rd_tag == TAG_M0);
    assign bus.m1_rvalid = (rd_tag == TAG_M1);
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.ram_rdata : {DATA_W{1'b0}};
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.ram_rdata : {DATA_W{1'b0}};
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    ram_arbiter_if #(.ADDR_W(30), .DATA_W(32)) bus ();

    ram_arbiter #(.ADDR_W(30), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr[7:0]];
        if (bus.ram_we) mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic cont_g0(input int i);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        return (i % 2) == 0;
`else
        return i != 4;
`endif
    endfunction

    task automatic check_returns(input string tag);
        logic [31:0] e0, e1;
        e0 = 32'h0;
        e1 = 32'h0;
        expect_eq({tag, ".rv0"}, 64'(bus.m0_rvalid), 64'(q0.size() != 0));
        expect_eq({tag, ".rv1"}, 64'(bus.m1_rvalid), 64'(q1.size() != 0));
        if (q0.size() != 0) e0 = q0.pop_front();
        if (q1.size() != 0) e1 = q1.pop_front();
        expect_eq({tag, ".rd0"}, 64'(bus.m0_rdata), 64'(e0));
        expect_eq({tag, ".rd1"}, 64'(bus.m1_rdata), 64'(e1));
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic step(input logic r0, input logic w0, input logic [29:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [29:0] a1, input logic [31:0] d1,
                        input logic lk, input logic eg0, input logic eg1, input string tag);
        logic        exp_re, exp_we;
        logic [29:0] exp_addr;
        bus.m0_re = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_re = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
        bus.m1_lock = lk;
        @(negedge clk);
        exp_re   = (eg0 & r0 & ~w0) | (eg1 & r1 & ~w1);
        exp_we   = (eg0 & w0) | (eg1 & w1);
        exp_addr = eg0 ? a0 : (eg1 ? a1 : 30'd0);
        expect_eq({tag, ".g0"}, 64'(bus.m0_gnt), 64'(eg0));
        expect_eq({tag, ".g1"}, 64'(bus.m1_gnt), 64'(eg1));
        expect_eq({tag, ".ram_re"}, 64'(bus.ram_re), 64'(exp_re));
        expect_eq({tag, ".ram_we"}, 64'(bus.ram_we), 64'(exp_we));
        expect_eq({tag, ".ram_addr"}, 64'(bus.ram_addr), 64'(exp_addr));
        check_returns(tag);
        if (eg0 && r0 && !w0) q0.push_back(ref_mem[a0[7:0]]);
        if (eg1 && r1 && !w1) q1.push_back(ref_mem[a1[7:0]]);
        if (eg0 && w0) ref_mem[a0[7:0]] = d0;
        if (eg1 && w1) ref_mem[a1[7:0]] = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 30'd0, 32'd0, 0, 0, 30'd0, 32'd0, 0, 0, 0, tag);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i) * 32'h11;
            ref_mem[i] = 32'(i) * 32'h11;
        end
        rst_n = 1'b0;
        bus.m0_re = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 30'd3; bus.m0_wdata = 32'd0;
        bus.m1_re = 1'b0; bus.m1_we = 1'b1; bus.m1_addr = 30'd4; bus.m1_wdata = 32'd9;
        bus.m1_lock = 1'b0;
        @(negedge clk);
        expect_eq("reset.g0", 64'(bus.m0_gnt), 64'd0);
        expect_eq("reset.g1", 64'(bus.m1_gnt), 64'd0);
        expect_eq("reset.ram_re", 64'(bus.ram_re), 64'd0);
        expect_eq("reset.ram_we", 64'(bus.ram_we), 64'd0);
        expect_eq("reset.ram_addr", 64'(bus.ram_addr), 64'd0);
        expect_eq("reset.rv0", 64'(bus.m0_rvalid), 64'd0);
        expect_eq("reset.rv1", 64'(bus.m1_rvalid), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single master write then read back
        step(0, 1, 30'h10, 32'hDEADBEEF, 0, 0, 30'd0, 32'd0, 0, 1, 0, "wr");
        step(1, 0, 30'h10, 32'd0,        0, 0, 30'd0, 32'd0, 0, 1, 0, "rd");
        idle("rd_ret");

        // alternating reads with no bubble
        step(1, 0, 30'd1, 32'd0, 0, 0, 30'd0, 32'd0, 0, 1, 0, "alt0");
        step(0, 0, 30'd0, 32'd0, 1, 0, 30'd2, 32'd0, 0, 0, 1, "alt1");
        idle("alt_ret");

        // re and we together act as a write
        step(1, 1, 30'h30, 32'hCAFEF00D, 0, 0, 30'd0, 32'd0, 0, 1, 0, "rw");
        step(1, 0, 30'h30, 32'd0,        0, 0, 30'd0, 32'd0, 0, 1, 0, "rw_rd");
        idle("rw_ret");

        // continuous contention
        for (int i = 0; i < 9; i++)
            step(1, 0, 30'd5, 32'd0, 1, 0, 30'd6, 32'd0, 0, cont_g0(i), !cont_g0(i), "cont");
        idle("cont_ret");

        // lock held for a few cycles, then released
        step(0, 0, 30'h43, 32'd0, 0, 1, 30'h40, 32'hA000, 1, 0, 1, "lk0");
        for (int k = 1; k < 4; k++)
            step(1, 0, 30'h43, 32'd0, 0, 1, 30'(32'h40 + k), 32'hA000 + 32'(k), 1, 0, 1, "lk");
        step(1, 0, 30'h43, 32'd0, 0, 0, 30'd0, 32'd0, 0, 0, 0, "lk_drop");
        step(1, 0, 30'h43, 32'd0, 0, 0, 30'd0, 32'd0, 0, 1, 0, "lk_m0");
        idle("lk_ret");

        // lock held forever: timer reopens and m0 wins one conflict
        step(0, 0, 30'h50, 32'd0, 0, 1, 30'h60, 32'hB0, 1, 0, 1, "to0");
        for (int k = 1; k < 9; k++)
            step(1, 0, 30'h50, 32'd0, 0, 1, 30'h60, 32'hB0 + 32'(k), 1, 0, 1, "to_lk");
        step(1, 0, 30'h50, 32'd0, 0, 1, 30'h60, 32'hBF, 1, 1, 0, "to_force");
        idle("to_ret");

        // reset asserted during a granted m1 read
        bus.m1_re = 1'b1; bus.m1_addr = 30'd7;
        @(negedge clk);
        expect_eq("rst_mid.g1", 64'(bus.m1_gnt), 64'd1);
        rst_n = 1'b0;
        #1;
        expect_eq("rst_mid.ram_re", 64'(bus.ram_re), 64'd0);
        expect_eq("rst_mid.g1_off", 64'(bus.m1_gnt), 64'd0);
        @(posedge clk);
        #1;
        bus.m1_re = 1'b0;
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
        idle("rst_post");
        for (int i = 0; i < 5; i++)
            step(1, 0, 30'd8, 32'd0, 1, 0, 30'd9, 32'd0, 0, cont_g0(i), !cont_g0(i), "rst_cont");
        idle("rst_ret");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port word-addressed RAM between two requesters:
  - master 0: the cpu memory port.
  - master 1: an auxiliary requester, e.g. a program loader or debug/DMA engine.
- Grants at most one access per cycle, drives the RAM port, and routes synchronous read data back to the issuing master.
- Sits between cpu/aux and the RAM. The cpu control FSM stalls its step on `m0_gnt` low.

Parameters:
- ADDR_W, 30, word address width; matches the RAM address.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive lost conflicts after which master 1 wins the next conflict; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_re  in  1  master 0 read request.
- m0_we  in  1  master 0 write request.
- m0_addr  in  ADDR_W  master 0 word address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access accepted this cycle.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_re, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for master 1.
- m1_lock  in  1  master 1 requests to keep ownership of the RAM on following cycles.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data; valid one cycle after `ram_re`.

Behaviour:
- Requests:
  - A master requests when its `re` or `we` is high.
  - `re` and `we` both high from one master is illegal. The arbiter then treats it as a write only.
- Grant:
  - The grant is combinational in the request cycle; the access completes in that cycle.
  - A master whose grant is low must hold its address, data and enables unchanged until it is granted.
- RAM port:
  - `ram_addr`, `ram_wdata`, `ram_re` and `ram_we` are muxed combinationally from the granted master.
  - With no grant, `ram_re` = `ram_we` = 0 and `ram_addr`/`ram_wdata` = 0.
- Arbitration (default, fixed priority with anti-starvation):
  - Only one master requesting: it is granted.
  - Both requesting:
    - master 0 wins if `wait_cnt` < MAX_WAIT;
    - otherwise master 1 wins.
- `wait_cnt` (4 bits):
  - increments when master 1 requests and is not granted, saturating at 15;
  - clears to 0 when master 1 is granted or stops requesting.
- Lock FSM, states OPEN and LOCKED:
  - OPEN -> LOCKED: master 1 granted while `m1_lock` = 1.
  - In LOCKED, master 1 has absolute priority and `m0_gnt` = 0.
  - LOCKED -> OPEN when any of these holds:
    - `m1_lock` = 0;
    - master 1 is idle for a cycle;
    - MAX_WAIT+4 locked cycles have elapsed. The lock timer then forces OPEN and master 0 gets priority for exactly one conflict.
- Read return:
  - A registered tag records which master, if any, issued the read in the previous cycle (NONE/M0/M1).
  - Next cycle, that master gets `rvalid` = 1 and `rdata` = `ram_rdata`; the other master gets `rvalid` = 0.
  - `m0_rdata` and `m1_rdata` are 0 whenever their `rvalid` is 0.
  - Back-to-back reads from alternating masters each return correctly; no bubble is required.
- Writes: complete in the grant cycle. No response signal.
- Reset (asynchronous, `rst_n` low):
  - state OPEN, `wait_cnt` = 0, lock timer = 0, read tag NONE;
  - all outputs 0, both `rvalid` = 0.
  - A read granted in the cycle reset asserts produces no `rvalid` after release.
- First cycle after `rst_n` rises: normal arbitration; master 0 has priority.

Optional Feature:
- Macro: `RAM_ARB_ROUND_ROBIN_EN`.
- Defined:
  - On a conflict, the master not granted at the last conflict wins. The priority pointer resets to master 0 winning first.
  - `wait_cnt` and MAX_WAIT are unused.
  - The lock FSM is unchanged.
- Undefined: fixed priority with anti-starvation, as above.

Test Plan:
- Single-master write and read: m0 writes 0xDEADBEEF to address 0x10, then reads 0x10 -> `m0_gnt` = 1 both cycles, `m0_rvalid` = 1 one cycle after the read, `m0_rdata` = 0xDEADBEEF, `m1_rvalid` stays 0.
- Contention, MAX_WAIT = 4, macro off: m0 and m1 read every cycle -> m0 granted cycles 0-3, m1 granted cycle 4, then `wait_cnt` = 0 and m0 granted cycles 5-8.
- Alternating reads: m0 reads address 1 (data 0x11) in cycle 0, m1 reads address 2 (data 0x22) in cycle 1 -> `m0_rvalid` with 0x11 in cycle 1, `m1_rvalid` with 0x22 in cycle 2.
- Lock: m1 asserts `m1_lock` with writes for 3 cycles while m0 requests -> `m0_gnt` = 0 for 3 cycles; m0 granted the cycle after `m1_lock` drops. Holding `m1_lock` indefinitely -> forced OPEN after 8 locked cycles and m0 wins one conflict.
- Reset mid-read: assert `rst_n` = 0 in the cycle m1 is granted a read -> after release both `rvalid` = 0 and `wait_cnt` = 0.
- Macro on, both masters requesting continuously -> grants alternate m0, m1, m0, m1 starting from m0.
